if_stage: RTL and testbench

- Instruction-fetch stage. Produces the {Inst, PC} stream that the decode stage consumes over the left_valid/left_ready handshake.
- Owns the fetch PC, drives the synchronous inst SRAM (1-cycle read latency) and buffers returned instructions in a small FIFO, so a decode stall never loses a fetched instruction.
- Accepts a redirect from the back end (branch/jump) that flushes all queued and in-flight fetches.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_stage_fifo.sv | 63 ++++++
 rtl/if_stage.sv | 145 ++++++++++++++
 tb/tb_if_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared constants and the fetch-entry type for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam logic [31:0] c_reset_pc     = 32'h1c00_0000;
  localparam logic [31:0] c_nop_inst     = 32'h0340_0000;
  localparam logic        c_reset_active = 1'b1;

  typedef struct packed {
    logic        excp;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_stage_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of fetch entries with single-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int BUF_DEPTH = 2,
  parameter int ENTRY_W   = 65
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [ENTRY_W-1:0]           push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(BUF_DEPTH):0]   count,
  output logic [ENTRY_W-1:0]           head
);

  localparam int c_ptr_w = $clog2(BUF_DEPTH);

  logic [ENTRY_W-1:0] r_mem [BUF_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC, inst SRAM requests, buffered {Inst, PC}
//            output. Optional macro IF_ALIGN_CHECK_EN adds misaligned-fetch
//            exception entries and the fetch_excp output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_reset_pc,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Inst,
  output logic [31:0] PC,
  output logic        right_valid,
`ifdef IF_ALIGN_CHECK_EN
  output logic        fetch_excp,
`endif
  input  logic        right_ready
);

  localparam int c_cnt_w = $clog2(BUF_DEPTH) + 1;
`ifdef IF_ALIGN_CHECK_EN
  localparam int c_entry_w = $bits(fetch_entry_t);
`else
  localparam int c_entry_w = 64;
`endif

  logic                 w_rst;
  logic [31:0]          r_fetch_pc;
  logic [31:0]          r_req_pc;
  logic                 r_inflight;
  logic [c_cnt_w-1:0]   w_count;
  logic [c_entry_w-1:0] w_push_data;
  logic [c_entry_w-1:0] w_head_data;
  logic                 w_fire;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_slot_ok;
  logic [c_cnt_w:0]     w_occupancy;
  logic [c_cnt_w:0]     w_capacity;

  assign w_rst       = (reset == c_reset_active);
  assign right_valid = (w_count != '0);
  assign w_fire      = right_valid & right_ready;

  // A slot is free when queued + in-flight entries, less the head leaving now, fit.
  assign w_occupancy = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_capacity  = (c_cnt_w + 1)'(BUF_DEPTH) + {{c_cnt_w{1'b0}}, w_fire};
  assign w_slot_ok   = ~w_rst & ~redirect_valid & (w_occupancy < w_capacity);

`ifdef IF_ALIGN_CHECK_EN
  logic         r_excp_stall;
  logic         w_misaligned;
  logic         w_excp_push;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head_entry;

  // A misaligned PC only arrives by redirect, so nothing is in flight then.
  assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
  assign w_issue      = w_slot_ok & ~w_misaligned & ~r_excp_stall;
  assign w_excp_push  = w_slot_ok & w_misaligned & ~r_excp_stall;
  assign w_push       = (r_inflight & ~redirect_valid) | w_excp_push;

  always_comb begin
    w_push_entry = '0;
    if (r_inflight) begin
      w_push_entry.pc   = r_req_pc;
      w_push_entry.inst = inst_sram_rdata;
    end else begin
      w_push_entry.excp = 1'b1;
      w_push_entry.pc   = r_fetch_pc;
      w_push_entry.inst = c_nop_inst;
    end
  end

  assign w_push_data  = w_push_entry;
  assign w_head_entry = w_head_data;
  assign Inst         = w_head_entry.inst;
  assign PC           = w_head_entry.pc;
  assign fetch_excp   = w_head_entry.excp;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_excp_stall <= 1'b0;
    end else if (redirect_valid) begin
      r_excp_stall <= 1'b0;
    end else if (w_excp_push) begin
      r_excp_stall <= 1'b1;
    end
  end
`else
  assign w_issue     = w_slot_ok;
  assign w_push      = r_inflight & ~redirect_valid;
  assign w_push_data = {r_req_pc, inst_sram_rdata};
  assign PC          = w_head_data[63:32];
  assign Inst        = w_head_data[31:0];
`endif

  assign inst_sram_en   = w_issue;
  assign inst_sram_addr = r_fetch_pc;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .BUF_DEPTH (BUF_DEPTH),
    .ENTRY_W   (c_entry_w)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (w_rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_fire),
    .flush     (redirect_valid),
    .count     (w_count),
    .head      (w_head_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] c_reset_pc = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] Inst;
  logic [31:0] PC;
  logic        right_valid;
  logic        right_ready = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
  logic        fetch_excp;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        model_on = 1'b0;
  int          since    = 0;
  logic [31:0] exp_pc   = c_reset_pc;
  logic [31:0] req_exp  = c_reset_pc;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .Inst            (Inst),
    .PC              (PC),
    .right_valid     (right_valid),
`ifdef IF_ALIGN_CHECK_EN
    .fetch_excp      (fetch_excp),
`endif
    .right_ready     (right_ready)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, data is the inverted address.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= ~inst_sram_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    right_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(right_valid), 32'd0);
    check("rst_en", 32'(inst_sram_en), 32'd0);
    check("rst_addr", inst_sram_addr, c_reset_pc);
    check("rst_inst", Inst, 32'd0);
    check("rst_pc", PC, 32'd0);
    model_on = 1'b1;
    since = 0;
    exp_pc = c_reset_pc;
    req_exp = c_reset_pc;
  endtask

  // One cycle: drive inputs, then compare against the delivered-stream model.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset = 1'b0;
    right_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    if (model_on) begin
      check("valid", 32'(right_valid), 32'(since >= 2));
      if (right_valid) begin
        check("head_pc", PC, exp_pc);
        check("head_inst", Inst, ~exp_pc);
`ifdef IF_ALIGN_CHECK_EN
        check("head_excp", 32'(fetch_excp), 32'd0);
`endif
      end
      if (rv) check("en_in_redirect", 32'(inst_sram_en), 32'd0);
      else if (inst_sram_en) check("req_addr", inst_sram_addr, req_exp);
      if (right_valid && rdy) exp_pc = exp_pc + 32'd4;
      if (inst_sram_en) req_exp = req_exp + 32'd4;
      if (rv) begin
        exp_pc = rpc;
        req_exp = rpc;
        since = 0;
      end else begin
        since++;
      end
    end
  endtask

  initial begin
    logic [31:0] tmp;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;

    // Streaming from reset with decode always ready.
    do_reset();
    cyc(1'b1, 1'b0, '0);
    check("t1_first_en", 32'(inst_sram_en), 32'd1);
    check("t1_first_addr", inst_sram_addr, c_reset_pc);
    cyc(1'b1, 1'b0, '0);
    check("t1_k1_valid", 32'(right_valid), 32'd0);
    cyc(1'b1, 1'b0, '0);
    check("t1_k2_valid", 32'(right_valid), 32'd1);
    check("t1_k2_pc", PC, 32'h1c00_0000);
    cyc(1'b1, 1'b0, '0);
    check("t1_k3_pc", PC, 32'h1c00_0004);
    cyc(1'b1, 1'b0, '0);
    check("t1_k4_pc", PC, 32'h1c00_0008);

    // Decode stall: fill, freeze, release.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b0, '0);
      if (k >= 3) begin
        check("t2_stall_en", 32'(inst_sram_en), 32'd0);
        check("t2_stall_pc", PC, 32'h1c00_0000);
      end
    end
    cyc(1'b1, 1'b0, '0);
    check("t2_rel0_pc", PC, 32'h1c00_0000);
    cyc(1'b1, 1'b0, '0);
    check("t2_rel1_pc", PC, 32'h1c00_0004);
    cyc(1'b1, 1'b0, '0);
    check("t2_rel2_pc", PC, 32'h1c00_0008);

    // Redirect with a queued entry and a request in flight.
    cyc(1'b0, 1'b1, 32'h1c00_0100);
    cyc(1'b1, 1'b0, '0);
    check("t3_req_en", 32'(inst_sram_en), 32'd1);
    check("t3_req_addr", inst_sram_addr, 32'h1c00_0100);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    check("t3_valid", 32'(right_valid), 32'd1);
    check("t3_pc", PC, 32'h1c00_0100);
    repeat (3) cyc(1'b1, 1'b0, '0);

    // Redirect on a firing head, then a second redirect.
    cyc(1'b1, 1'b1, 32'h1c00_0180);
    cyc(1'b1, 1'b1, 32'h1c00_0200);
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t4_pc", PC, 32'h1c00_0200);
    repeat (2) cyc(1'b1, 1'b0, '0);

    // Wrap of the fetch PC.
    cyc(1'b1, 1'b1, 32'hffff_fff8);
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t5_pc0", PC, 32'hffff_fff8);
    cyc(1'b1, 1'b0, '0);
    check("t5_pc1", PC, 32'hffff_fffc);
    cyc(1'b1, 1'b0, '0);
    check("t5_pc2", PC, 32'h0000_0000);
    check("t5_inst2", Inst, 32'hffff_ffff);

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned redirect target produces one exception entry, then idles.
    model_on = 1'b0;
    cyc(1'b1, 1'b1, 32'h1c00_0102);
    cyc(1'b1, 1'b0, '0);
    check("t6_no_req", 32'(inst_sram_en), 32'd0);
    cyc(1'b1, 1'b0, '0);
    check("t6_valid", 32'(right_valid), 32'd1);
    check("t6_pc", PC, 32'h1c00_0102);
    check("t6_inst", Inst, 32'h0340_0000);
    check("t6_excp", 32'(fetch_excp), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, '0);
      check("t6_idle_valid", 32'(right_valid), 32'd0);
      check("t6_idle_en", 32'(inst_sram_en), 32'd0);
    end
    model_on = 1'b1;
    since = 0;
    cyc(1'b1, 1'b1, 32'h1c00_0300);
    repeat (4) cyc(1'b1, 1'b0, '0);
`endif

    // Randomized ready/redirect traffic, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 15) == 0);
      tmp = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hffff_fff0 + 32'($urandom_range(0, 3)) * 32'd4;
      else rpc = {tmp[31:2], 2'b00};
      cyc(rdy, rv, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
